sram_bank: RTL and testbench

Multi-bank synchronous SRAM that answers the memory controller of the dot-product datapath. It accepts per-bank chip-select, read/write enables and packed addresses, and returns registered read data with a valid strobe. It also runs a per-bank zero-fill sweep on request. Bank 0 and bank 1 hold the two input vectors, and bank 2 holds the output vector; the block itself treats all banks identically.

---
 rtl/sram_pkg.sv | 12 +
 rtl/sram_bank_if.sv | 29 ++
 rtl/sram_bank_slice.sv | 66 ++++++
 rtl/sram_bank.sv | 35 +++
 tb/tb_sram_bank.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// sram_pkg: shared defaults, bank state encoding and address range check for sram_bank
package sram_pkg;
  localparam int ADDR_WIDTH = 4;
  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int NUMS_SRAM = 3;
  localparam int DATA_WIDTH = 8;
  typedef enum logic {ST_IDLE, ST_CLEAR} bank_state_e;
  // An address slice is usable only when every bit above the decoded field is zero.
  function automatic logic addr_ok(input logic [31:0] addr, input int aw);
    return (addr >> aw) == 32'd0;
  endfunction
endpackage

// File: rtl/sram_bank_if.sv
// sram_bank_if: packed per-bank request/response bus between the memory controller and sram_bank
// master: controller side (drives clear/enables/addresses/write data)
// slave: memory side (drives Data_Read, Rd_Valid, Clear_Busy, Addr_Err)
interface sram_bank_if import sram_pkg::*; #(
  parameter int Addr_Width = ADDR_WIDTH,
  parameter int Ram_Depth = 1 << Addr_Width,
  parameter int Nums_SRAM = NUMS_SRAM,
  parameter int Data_Width = DATA_WIDTH
) ();
  logic [Nums_SRAM-1:0] Mem_Clear;
  logic [Nums_SRAM-1:0] En_Chip_Select;
  logic [Nums_SRAM-1:0] En_Read;
  logic [Nums_SRAM-1:0] En_Write;
  logic [Nums_SRAM*Ram_Depth-1:0] Addr_Read;
  logic [Nums_SRAM*Ram_Depth-1:0] Addr_Write;
  logic [Nums_SRAM*Data_Width-1:0] Data_Write;
  logic [Nums_SRAM*Data_Width-1:0] Data_Read;
  logic [Nums_SRAM-1:0] Rd_Valid;
  logic [Nums_SRAM-1:0] Clear_Busy;
  logic [Nums_SRAM-1:0] Addr_Err;
  modport master (
    output Mem_Clear, En_Chip_Select, En_Read, En_Write, Addr_Read, Addr_Write, Data_Write,
    input Data_Read, Rd_Valid, Clear_Busy, Addr_Err
  );
  modport slave (
    input Mem_Clear, En_Chip_Select, En_Read, En_Write, Addr_Read, Addr_Write, Data_Write,
    output Data_Read, Rd_Valid, Clear_Busy, Addr_Err
  );
endinterface

// File: rtl/sram_bank_slice.sv
// sram_bank_slice: one SRAM bank with registered read, range check and zero-fill sweep
// ports: clk, rst_n (async active-low), clear/cs/rd/wr requests, addr_rd/addr_wr slices,
// data_wr in; data_rd, rd_valid, clear_busy, addr_err out
// SRAM_FWD_EN: when defined, a same-address read during an accepted write returns the new data
module sram_bank_slice import sram_pkg::*; #(
  parameter int Addr_Width = ADDR_WIDTH,
  parameter int Ram_Depth = 1 << Addr_Width,
  parameter int Data_Width = DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  cs,
  input  logic                  rd,
  input  logic                  wr,
  input  logic [Ram_Depth-1:0]  addr_rd,
  input  logic [Ram_Depth-1:0]  addr_wr,
  input  logic [Data_Width-1:0] data_wr,
  output logic [Data_Width-1:0] data_rd,
  output logic                  rd_valid,
  output logic                  clear_busy,
  output logic                  addr_err
);
  logic [Data_Width-1:0] mem [Ram_Depth];
  bank_state_e state, state_nxt;
  logic [Addr_Width-1:0] clr_cnt, clr_cnt_nxt, ra, wa;
  logic rd_ok, wr_ok, rd_acc, wr_acc;
  logic [Data_Width-1:0] rd_word;
  assign ra = addr_rd[Addr_Width-1:0];
  assign wa = addr_wr[Addr_Width-1:0];
  assign rd_ok = addr_ok(32'(addr_rd), Addr_Width);
  assign wr_ok = addr_ok(32'(addr_wr), Addr_Width);
  assign clear_busy = state == ST_CLEAR;
  assign rd_acc = cs & rd & ~clear_busy & rd_ok;
  assign wr_acc = cs & wr & ~clear_busy & wr_ok;
`ifdef SRAM_FWD_EN
  assign rd_word = (wr_acc && wa == ra) ? data_wr : mem[ra];
`else
  assign rd_word = mem[ra];
`endif
  // A held clear request on the final sweep word chains straight into a new sweep.
  always_comb begin
    state_nxt = (state == ST_IDLE) ? (clear ? ST_CLEAR : ST_IDLE) : ((&clr_cnt && !clear) ? ST_IDLE : ST_CLEAR);
    clr_cnt_nxt = clear_busy ? clr_cnt + 1'b1 : clr_cnt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      clr_cnt <= '0;
      data_rd <= '0;
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      state <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
      rd_valid <= rd_acc;
      addr_err <= cs & ((rd & ~rd_ok) | (wr & ~wr_ok));
      if (rd_acc) data_rd <= rd_word;
    end
  end
  // The array is deliberately not reset; an aborted sweep leaves untouched words intact.
  always_ff @(posedge clk) begin
    if (clear_busy) mem[clr_cnt] <= '0;
    else if (wr_acc) mem[wa] <= data_wr;
  end
endmodule

// File: rtl/sram_bank.sv
// sram_bank: Nums_SRAM independent SRAM banks behind a packed per-bank bus
// ports: clk, Mem_reset_n (async active-low), bus (sram_bank_if.slave)
// SRAM_FWD_EN: selects write-first bypass in every bank (read-first when undefined)
module sram_bank import sram_pkg::*; #(
  parameter int Addr_Width = ADDR_WIDTH,
  parameter int Ram_Depth = 1 << Addr_Width,
  parameter int Nums_SRAM = NUMS_SRAM,
  parameter int Data_Width = DATA_WIDTH
) (
  input logic        clk,
  input logic        Mem_reset_n,
  sram_bank_if.slave bus
);
  for (genvar i = 0; i < Nums_SRAM; i++) begin : g_bank
    sram_bank_slice #(
      .Addr_Width(Addr_Width),
      .Ram_Depth(Ram_Depth),
      .Data_Width(Data_Width)
    ) u_slice (
      .clk(clk),
      .rst_n(Mem_reset_n),
      .clear(bus.Mem_Clear[i]),
      .cs(bus.En_Chip_Select[i]),
      .rd(bus.En_Read[i]),
      .wr(bus.En_Write[i]),
      .addr_rd(bus.Addr_Read[Ram_Depth*i +: Ram_Depth]),
      .addr_wr(bus.Addr_Write[Ram_Depth*i +: Ram_Depth]),
      .data_wr(bus.Data_Write[Data_Width*i +: Data_Width]),
      .data_rd(bus.Data_Read[Data_Width*i +: Data_Width]),
      .rd_valid(bus.Rd_Valid[i]),
      .clear_busy(bus.Clear_Busy[i]),
      .addr_err(bus.Addr_Err[i])
    );
  end
endmodule

// File: tb/tb_sram_bank.sv
// tb_sram_bank: scoreboard bench for sram_bank against a word-array reference model
module tb_sram_bank;
  import sram_pkg::*;
  logic clk = 1'b0;
  logic Mem_reset_n = 1'b0;
  always #5 clk = ~clk;
  sram_bank_if bus();
  sram_bank dut (.clk(clk), .Mem_reset_n(Mem_reset_n), .bus(bus));
  typedef struct {int tag; logic rv; logic err; logic [7:0] data;} exp_t;
  exp_t q[3][$];
  logic [7:0] mem[3][16];
  int left[3];
  logic [7:0] exp_dr[3];
  int edge_cnt = 0;
  int n_cmp = 0;
  int n_bad = 0;
  always @(posedge clk) edge_cnt++;
  task automatic chk(input string nm, input int b, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s bank%0d: got %0h expected %0h (t=%0t)", nm, b, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    logic due;
    exp_t e;
    if (Mem_reset_n) begin
      for (int i = 0; i < 3; i++) begin
        due = q[i].size() > 0 && q[i][0].tag <= edge_cnt;
        if (due) begin
          e = q[i].pop_front();
          chk("rd_valid", i, 32'(bus.Rd_Valid[i]), 32'(e.rv));
          chk("addr_err", i, 32'(bus.Addr_Err[i]), 32'(e.err));
          if (e.rv) exp_dr[i] = e.data;
        end else if (bus.Rd_Valid[i] || bus.Addr_Err[i]) begin
          chk("unexpected_strobe", i, {30'd0, bus.Rd_Valid[i], bus.Addr_Err[i]}, 32'd0);
        end
        chk("data_read", i, 32'(bus.Data_Read[8*i +: 8]), 32'(exp_dr[i]));
        chk("clear_busy", i, 32'(bus.Clear_Busy[i]), 32'(left[i] != 0));
      end
    end
  end
  task automatic drive_zero();
    bus.Mem_Clear = '0;
    bus.En_Chip_Select = '0;
    bus.En_Read = '0;
    bus.En_Write = '0;
    bus.Addr_Read = '0;
    bus.Addr_Write = '0;
    bus.Data_Write = '0;
  endtask
  task automatic step(input logic [2:0] clr, cs, rd, wr, input logic [47:0] ar, aw, input logic [23:0] dw);
    @(negedge clk);
    #1;
    bus.Mem_Clear = clr;
    bus.En_Chip_Select = cs;
    bus.En_Read = rd;
    bus.En_Write = wr;
    bus.Addr_Read = ar;
    bus.Addr_Write = aw;
    bus.Data_Write = dw;
    for (int i = 0; i < 3; i++) begin
      logic [15:0] a_r, a_w;
      logic okr, okw, busy, racc, wacc, err;
      logic [7:0] d, wd;
      a_r = ar[16*i +: 16];
      a_w = aw[16*i +: 16];
      wd = dw[8*i +: 8];
      okr = a_r[15:4] == 12'd0;
      okw = a_w[15:4] == 12'd0;
      busy = left[i] != 0;
      racc = cs[i] && rd[i] && !busy && okr;
      wacc = cs[i] && wr[i] && !busy && okw;
      err = cs[i] && ((rd[i] && !okr) || (wr[i] && !okw));
      d = mem[i][a_r[3:0]];
`ifdef SRAM_FWD_EN
      if (wacc && a_w[3:0] == a_r[3:0]) d = wd;
`endif
      if (racc || err) q[i].push_back('{edge_cnt + 1, racc, err, d});
      if (busy) begin
        mem[i][16 - left[i]] = 8'h00;
        left[i]--;
        if (left[i] == 0 && clr[i]) left[i] = 16;
      end else begin
        if (wacc) mem[i][a_w[3:0]] = wd;
        if (clr[i]) left[i] = 16;
      end
    end
  endtask
  task automatic idle();
    step(3'b0, 3'b0, 3'b0, 3'b0, 48'd0, 48'd0, 24'd0);
  endtask
  task automatic wr1(input int b, input int a, input logic [7:0] d);
    step(3'b0, 3'(1 << b), 3'b0, 3'(1 << b), 48'd0, 48'(a) << (16 * b), 24'(d) << (8 * b));
  endtask
  task automatic rd1(input int b, input int a);
    step(3'b0, 3'(1 << b), 3'(1 << b), 3'b0, 48'(a) << (16 * b), 48'd0, 24'd0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    #1;
    Mem_reset_n = 1'b0;
    drive_zero();
    #1;
    chk("rst_data_read", 0, 32'(bus.Data_Read), 32'd0);
    chk("rst_rd_valid", 0, 32'(bus.Rd_Valid), 32'd0);
    chk("rst_clear_busy", 0, 32'(bus.Clear_Busy), 32'd0);
    chk("rst_addr_err", 0, 32'(bus.Addr_Err), 32'd0);
    for (int i = 0; i < 3; i++) begin
      q[i].delete();
      left[i] = 0;
      exp_dr[i] = 8'h00;
    end
    repeat (2) @(negedge clk);
    #1;
    Mem_reset_n = 1'b1;
  endtask
  initial begin
    drive_zero();
    do_reset();
    for (int a = 0; a < 16; a++)
      step(3'b0, 3'b111, 3'b0, 3'b111, 48'd0, {16'(a), 16'(a), 16'(a)}, 24'($urandom));
    wr1(2, 3, 8'hA5);
    rd1(2, 3);
    wr1(0, 5, 8'h11);
    step(3'b0, 3'b001, 3'b001, 3'b001, 48'd5, 48'd5, 24'h22);
    rd1(0, 5);
    for (int a = 0; a < 16; a++) wr1(1, a, 8'hFF);
    step(3'b010, 3'b0, 3'b0, 3'b0, 48'd0, 48'd0, 24'd0);
    for (int a = 0; a < 16; a++) rd1(1, a);
    for (int a = 0; a < 16; a++) rd1(1, a);
    rd1(0, 7);
    rd1(0, 16'h0010);
    step(3'b0, 3'b001, 3'b001, 3'b001, 48'h0100, 48'h8000, 24'h5A);
    idle();
    for (int a = 0; a < 16; a++) wr1(2, a, 8'(8'h80 | 8'($urandom)));
    step(3'b100, 3'b0, 3'b0, 3'b0, 48'd0, 48'd0, 24'd0);
    repeat (8) idle();
    do_reset();
    for (int a = 0; a < 16; a++) rd1(2, a);
    for (int a = 0; a < 16; a++)
      step(3'b0, 3'b111, 3'b011, 3'b100, {16'd0, 16'(a), 16'(a)}, {16'(a), 32'd0},
           {8'(mem[0][a] + mem[1][a]), 16'd0});
    for (int n = 0; n < 800; n++) begin
      logic [2:0] clr;
      logic [47:0] ar, aw;
      for (int i = 0; i < 3; i++) begin
        logic [15:0] x, y;
        clr[i] = $urandom_range(0, 60) == 0;
        x = 16'($urandom_range(0, 15));
        y = 16'($urandom_range(0, 15));
        if ($urandom_range(0, 9) == 0) x = x | (16'd1 << $urandom_range(4, 15));
        if ($urandom_range(0, 9) == 0) y = y | (16'd1 << $urandom_range(4, 15));
        ar[16*i +: 16] = x;
        aw[16*i +: 16] = y;
      end
      step(clr, 3'($urandom), 3'($urandom), 3'($urandom), ar, aw, 24'($urandom));
    end
    repeat (40) idle();
    for (int i = 0; i < 3; i++) chk("scoreboard_drained", i, 32'(q[i].size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
